// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter and its FIFO.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   // Parity bit for up to 9 data bits; zero-extension does not change the XOR.
   function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
      return (^data) ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-around pointers and an occupancy counter.
// Accept/pop decisions use the occupancy before the edge.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   i_clock,
   input  logic                   i_reset_n,
   input  logic                   i_wr_en,
   input  logic [WIDTH-1:0]       i_wr_data,
   input  logic                   i_rd_en,
   output logic [WIDTH-1:0]       o_rd_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_wr;
   logic             w_rd;

   assign w_wr      = i_wr_en && (r_count != LP_FULL);
   assign w_rd      = i_rd_en && (r_count != '0);
   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_full    = (r_count == LP_FULL);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;

   // Storage needs no reset: the cleared pointers and counter hide stale entries
   always_ff @(posedge i_clock) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Occupancy: simultaneous write and pop leaves it unchanged
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count <= '0;
      end else begin
         unique case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: start bit, DATA_W bits LSB first,
// optional parity, STOP_BITS stop bits. Frames chain with no idle gap.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   wr_en,
   input  logic [DATA_W-1:0]      wr_data,
   output logic                   tx,
   output logic                   busy,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int unsigned   CW           = $clog2(CLKS_PER_BIT);
   localparam int unsigned   IW           = $clog2(DATA_W);
   localparam logic [CW-1:0] LP_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LP_IDX_LAST  = IW'(DATA_W - 1);
   localparam logic          LP_STOP_LAST = 1'(STOP_BITS - 1);

   uart_state_t       r_state;
   uart_state_t       w_state_nxt;
   logic [CW-1:0]     r_bit_cnt;
   logic [IW-1:0]     r_bit_idx;
   logic              r_stop_idx;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] w_shift_nxt;
   logic              r_parity;
   logic              r_tx;
   logic              r_overflow;
   logic              w_tx_nxt;
   logic              w_bit_done;
   logic              w_stop_done;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [DATA_W-1:0] w_rd_data;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_wr_en   (wr_en),
      .i_wr_data (wr_data),
      .i_rd_en   (w_pop),
      .o_rd_data (w_rd_data),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (count)
   );

   assign full        = w_full;
   assign empty       = w_empty;
   assign overflow    = r_overflow;
   assign tx          = r_tx;
   assign w_bit_done  = (r_bit_cnt == LP_BIT_LAST);
   assign w_stop_done = (r_state == ST_STOP) && w_bit_done && (r_stop_idx == LP_STOP_LAST);
   assign w_pop       = !w_empty && ((r_state == ST_IDLE) || w_stop_done);

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state: each state advances on its bit boundary
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:   if (!w_empty) w_state_nxt = ST_START;
         ST_START:  if (w_bit_done) w_state_nxt = ST_DATA;
         ST_DATA:   if (w_bit_done && (r_bit_idx == LP_IDX_LAST))
                       w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
         ST_PARITY: if (w_bit_done) w_state_nxt = ST_STOP;
         ST_STOP:   if (w_stop_done) w_state_nxt = w_empty ? ST_IDLE : ST_START;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Shift register next value: load on pop, shift at each data-bit boundary
   always_comb begin
      w_shift_nxt = r_shift;
      if (w_pop)                                      w_shift_nxt = w_rd_data;
      else if ((r_state == ST_DATA) && w_bit_done)    w_shift_nxt = r_shift >> 1;
   end

   // Outputs: busy from state; tx computed from next state so the line is registered
   always_comb begin
      busy     = (r_state != ST_IDLE);
      w_tx_nxt = 1'b1;
      unique case (w_state_nxt)
         ST_START:  w_tx_nxt = 1'b0;
         ST_DATA:   w_tx_nxt = w_shift_nxt[0];
         ST_PARITY: w_tx_nxt = r_parity;
         default:   w_tx_nxt = 1'b1;
      endcase
   end

   // Serial line register, idle high
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_tx <= 1'b1;
      else          r_tx <= w_tx_nxt;
   end

   // Bit timer reloads on every bit boundary; bit and stop indices per state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_bit_cnt  <= '0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) || w_bit_done) r_bit_cnt <= '0;
         else                                    r_bit_cnt <= r_bit_cnt + 1'b1;
         if (r_state != ST_DATA)  r_bit_idx <= '0;
         else if (w_bit_done)     r_bit_idx <= r_bit_idx + 1'b1;
         if (r_state != ST_STOP)  r_stop_idx <= 1'b0;
         else if (w_bit_done)     r_stop_idx <= ~r_stop_idx;
      end
   end

   // Frame data and its parity are captured together at pop time
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_shift  <= '0;
         r_parity <= 1'b0;
      end else begin
         r_shift <= w_shift_nxt;
         if (w_pop) r_parity <= parity_bit(9'(w_rd_data), PARITY);
      end
   end

   // Sticky overflow on any write attempted while full
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_overflow <= 1'b0;
      else          r_overflow <= r_overflow | (wr_en & w_full);
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8: character width in bits (5..9).
REQ-002 Parameter DEPTH, default 16: FIFO entries, power of two, >= 2.
REQ-003 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit, >= 2.
REQ-004 Parameter PARITY, default 0: parity mode, 0 = none, 1 = even, 2 = odd.
REQ-005 Parameter STOP_BITS, default 1: stop bits per frame, 1 or 2.
REQ-006 clock  in  1  sole clock; all state SHALL update on the rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 wr_en  in  1  write strobe, sampled on every rising edge (same role as the CPU uart_out[8] flag).
REQ-009 wr_data  in  DATA_W  character to queue.
REQ-010 tx  out  1  serial line, idle high.
REQ-011 busy  out  1  high while a frame is being shifted out.
REQ-012 full  out  1  FIFO holds DEPTH entries.
REQ-013 empty  out  1  FIFO holds 0 entries.
REQ-014 count  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 overflow  out  1  sticky flag: a write was dropped.

Function
REQ-016 A write SHALL be accepted on an edge where wr_en=1 and full=0; one entry is stored per edge, so a multi-cycle wr_en queues one copy per cycle.
REQ-017 A write with full=1 SHALL be discarded and SHALL set overflow, which then stays 1 until reset.
REQ-018 A write and a pop on the same edge SHALL leave count unchanged; the full/empty decision SHALL use the pre-edge count.
REQ-019 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-020 The FSM SHALL skip the PARITY state when PARITY=0.
REQ-021 In IDLE with empty=0, the next edge SHALL pop the head entry into the shift register, enter START and drive tx=0.
REQ-022 Consequently, a write captured at edge E into an empty idle FIFO SHALL drive tx low at edge E+1.
REQ-023 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter that reloads on every bit boundary.
REQ-024 DATA SHALL transmit DATA_W bits LSB first.
REQ-025 PARITY SHALL transmit the XOR of the data bits for even mode and its inverse for odd mode.
REQ-026 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-027 Frame length SHALL be CLKS_PER_BIT*(1+DATA_W+(PARITY!=0)+STOP_BITS) cycles.
REQ-028 At the final cycle of STOP, a non-empty FIFO SHALL pop and enter START directly with no idle gap; otherwise the FSM returns to IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 tx SHALL be registered with no combinational path from inputs.

Reset
REQ-031 reset_n=0 SHALL immediately force tx=1, busy=0, empty=1, full=0, count=0, overflow=0, state=IDLE and clear both FIFO pointers.
REQ-032 Reset mid-frame SHALL abandon the frame and discard all queued data.
REQ-033 After reset_n returns to 1, no transmission SHALL begin until a new write is accepted.

Structure
REQ-034 Package uart_pkg SHALL hold the FSM state typedef and the parity-mode constants PAR_NONE, PAR_EVEN and PAR_ODD.
REQ-035 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH) with wrap-around pointers and an occupancy counter.
REQ-036 The framing FSM and bit timer SHALL reside in uart_tx_fifo.

Verification
Unless stated otherwise, benches use CLKS_PER_BIT=4, DATA_W=8, DEPTH=4, PARITY=0, STOP_BITS=1.
REQ-037 Write 0x41 once -> tx = 0,1,0,0,0,0,0,1,0,1, each bit 4 clocks; busy high for 40 clocks; then IDLE with tx=1.
REQ-038 Write 0x55 then 0xAA on consecutive edges -> two frames, second start bit immediately after first stop; busy high 80 consecutive clocks.
REQ-039 Write 0x01..0x06 on six consecutive edges -> 0x01..0x05 transmitted in order, 0x06 dropped, full=1 after 5th write, overflow=1 and stays 1.
REQ-040 PARITY=1, write 0x07 -> parity bit 1; PARITY=2, write 0x07 -> parity bit 0; frame 44 clocks each.
REQ-041 Write 0x00 and 0x11; assert reset_n=0 during data bit 3 -> tx=1 same cycle, count=0, busy=0; release reset -> tx stays 1 for 100 clocks.
REQ-042 STOP_BITS=2, write 0x80 and 0x01 back-to-back -> tx high exactly 8 clocks between last data bit and next start bit.
